load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Memory-access stage directly downstream of the ALU operand mux and ALU in the single-cycle RV32I core.
- Takes the computed effective address, the store data (rs2), the control-unit memread/memwrite and funct3, and runs a req/ready transaction to a variable-latency data memory.
- Stalls the program counter until the access completes.
- Handles byte enables, store-data replication, load extraction and sign/zero extension, misalignment and illegal-encoding detection, and a bus timeout.

Parameters:
- MAX_WAIT, 15, max cycles in ACCESS without mem_ready before timeout (range 1..255).
- CNT_W, 8, width of the wait counter.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous active-high reset
- memread  in  1  load instruction in flight (from Main_Control_Unit)
- memwrite  in  1  store instruction in flight
- funct3  in  3  instruction[14:12]
- addr  in  32  effective address from ALU
- store_data  in  32  rs2 value from Register_File
- load_data  out  32  extended load result, registered
- stall  out  1  hold PC and register writeback
- misaligned  out  1  combinational pulse, alignment fault
- bus_error  out  1  one-cycle pulse: timeout, illegal funct3, or memread&memwrite
- mem_req  out  1  request to data memory
- mem_we  out  1  1 = write
- mem_addr  out  32  word address {addr[31:2],2'b00}
- mem_wdata  out  32  replicated store data
- mem_be  out  4  byte enables
- mem_ready  in  1  memory accepts / returns data this cycle
- mem_rdata  in  32  read word, valid when mem_ready

Behaviour:
- One clock, clk. Reset is synchronous and active-high on port reset.
- Reset values: state IDLE, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, mem_be 0, load_data 0, wait counter 0, bus_error 0.
- Reset mid-access forces IDLE at that edge. mem_ready asserted in the reset cycle or afterwards is ignored.

- FSM states: IDLE, ACCESS, DONE.
  - IDLE: a launch occurs when (memread XOR memwrite), the funct3 is legal and the access is aligned.
  - On a launch: stall=1 combinationally in that cycle. Next edge latches mem_we, mem_addr, mem_wdata, mem_be, funct3 and addr[1:0], then goes to ACCESS.
  - ACCESS: mem_req=1 and stall=1, request fields held stable.
  - In ACCESS with mem_ready=1: next edge goes to DONE, mem_req drops, and for loads load_data is updated.
  - In ACCESS with counter==MAX_WAIT-1 and no ready: next edge goes to DONE, bus_error=1 during the DONE cycle, load_data=0.
  - DONE: stall=0 and no new launch is taken, even though memread/memwrite are still high. The PC advances at this edge. Next state is IDLE.
- Fault cases (no launch, stall=0):
  - Legal funct3 with misaligned address: misaligned=1 combinationally in IDLE.
  - Illegal funct3 or memread&memwrite: bus_error=1 combinationally in IDLE.
- Minimum latency: launch cycle + 1 ACCESS cycle + DONE = 3 cycles.
- load_data holds its value until the next load completes. Stores never modify it.
- Legal funct3 codes:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - All other codes are illegal.
- Alignment: halfword needs addr[0]=0; word needs addr[1:0]=00.
- Byte enables:
  - Byte: 4'b0001<<addr[1:0].
  - Half: 4'b0011<<addr[1:0] (so 0011 or 1100).
  - Word: 1111. Loads also drive mem_be by size.
- Write data: byte {4{sd[7:0]}}, half {2{sd[15:0]}}, word sd.
- Load extraction: shifted = mem_rdata >> (8*addr[1:0]). LB/LH sign-extend bit 7/15; LBU/LHU zero-extend.
- Wait counter clears on entry to ACCESS and saturates at MAX_WAIT-1.

Decomposition:
- Package lsu_pkg holds:
  - funct3 localparams: F3_B=3'b000, F3_H=3'b001, F3_W=3'b010, F3_BU=3'b100, F3_HU=3'b101.
  - State encoding: IDLE=2'd0, ACCESS=2'd1, DONE=2'd2.
- One combinational sub-module, lsu_align: funct3 and addr[1:0] in; be, wdata replicate, misaligned, illegal and load-extend out.
- The FSM and registers stay in load_store_unit.

Test Plan:
- SW addr=0x100, sd=0xDEADBEEF, mem_ready on 1st ACCESS cycle -> mem_be=1111, mem_wdata=0xDEADBEEF, mem_addr=0x100, stall high 2 cycles then low in DONE.
- LB addr=0x203, rdata=0x80FF_1234, ready after 3 wait cycles -> load_data=0xFFFFFF80; same with LBU -> 0x00000080; stall high 5 cycles.
- SH addr=0x12, sd=0x0000ABCD -> mem_be=1100, mem_wdata=0xABCDABCD, mem_addr=0x10.
- LW addr=0x101 -> misaligned=1, stall=0, mem_req stays 0. funct3=011 load -> bus_error=1, no request.
- LW, mem_ready never asserted, MAX_WAIT=15 -> 15 ACCESS cycles, then DONE with bus_error=1 and load_data=0.
- Reset asserted in 2nd ACCESS cycle, mem_ready pulsed 1 cycle later -> IDLE, mem_req=0 after the edge, load_data=0, response ignored.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: funct3 access sizes and FSM states.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational size/alignment logic: byte enables, store replication,
// alignment and encoding checks on the request side, and load extraction
// on the response side (driven by the funct3/offset latched at launch).
module lsu_align
  import lsu_pkg::*;
(
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [2:0]  rsp_funct3,
  input  logic [1:0]  rsp_addr_lo,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic        misaligned,
  output logic        illegal,
  output logic [31:0] load_ext
);

  logic [31:0] shifted;

  // Request side: enables, replicated write data and fault flags by size.
  always_comb begin
    be         = 4'b0000;
    wdata      = store_data;
    misaligned = 1'b0;
    illegal    = 1'b0;
    case (funct3)
      F3_B: begin
        be    = 4'b0001 << addr_lo;
        wdata = {4{store_data[7:0]}};
      end
      F3_H: begin
        be         = 4'b0011 << addr_lo;
        wdata      = {2{store_data[15:0]}};
        misaligned = addr_lo[0];
      end
      F3_W: begin
        be         = 4'b1111;
        misaligned = |addr_lo;
      end
      // Unsigned variants exist only for loads.
      F3_BU: begin
        be      = 4'b0001 << addr_lo;
        illegal = is_store;
      end
      F3_HU: begin
        be         = 4'b0011 << addr_lo;
        misaligned = addr_lo[0];
        illegal    = is_store;
      end
      default: illegal = 1'b1;
    endcase
  end

  // Response side: shift the addressed lane down, then sign/zero extend.
  always_comb begin
    shifted  = rdata >> {rsp_addr_lo, 3'b000};
    load_ext = shifted;
    case (rsp_funct3)
      F3_B:    load_ext = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    load_ext = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   load_ext = {24'd0, shifted[7:0]};
      F3_HU:   load_ext = {16'd0, shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: launches one req/ready transaction per load/store,
// stalls the core until it completes, and flags alignment, encoding and
// timeout faults.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic        stall,
  output logic        misaligned,
  output logic        bus_error,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

  lsu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mem_req_q, mem_req_d;
  logic             mem_we_q, mem_we_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic [31:0]      mem_wdata_q, mem_wdata_d;
  logic [3:0]       mem_be_q, mem_be_d;
  logic [2:0]       f3_q, f3_d;
  logic [1:0]       alo_q, alo_d;
  logic [31:0]      load_data_q, load_data_d;
  logic             bus_err_q, bus_err_d;

  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic        al_misaligned;
  logic        al_illegal;
  logic [31:0] al_load_ext;
  logic        one_op;
  logic        launch;

  lsu_align u_align (
    .is_store    (memwrite),
    .funct3      (funct3),
    .addr_lo     (addr[1:0]),
    .store_data  (store_data),
    .rsp_funct3  (f3_q),
    .rsp_addr_lo (alo_q),
    .rdata       (mem_rdata),
    .be          (al_be),
    .wdata       (al_wdata),
    .misaligned  (al_misaligned),
    .illegal     (al_illegal),
    .load_ext    (al_load_ext)
  );

  // Next-state, request latching and combinational handshake/fault outputs.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    f3_d        = f3_q;
    alo_d       = alo_q;
    load_data_d = load_data_q;
    bus_err_d   = 1'b0;
    one_op      = memread ^ memwrite;
    launch      = 1'b0;
    misaligned  = 1'b0;
    bus_error   = bus_err_q;
    stall       = 1'b0;

    case (state_q)
      IDLE: begin
        launch     = one_op && !al_illegal && !al_misaligned;
        misaligned = one_op && !al_illegal && al_misaligned;
        bus_error  = (memread && memwrite) || (one_op && al_illegal);
        stall      = launch;
        if (launch) begin
          state_d     = ACCESS;
          cnt_d       = '0;
          mem_req_d   = 1'b1;
          mem_we_d    = memwrite;
          mem_addr_d  = {addr[31:2], 2'b00};
          mem_wdata_d = al_wdata;
          mem_be_d    = al_be;
          f3_d        = funct3;
          alo_d       = addr[1:0];
        end
      end
      ACCESS: begin
        stall = 1'b1;
        if (mem_ready) begin
          state_d   = DONE;
          mem_req_d = 1'b0;
          if (!mem_we_q) load_data_d = al_load_ext;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = DONE;
          mem_req_d = 1'b0;
          bus_err_d = 1'b1;
          if (!mem_we_q) load_data_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      // Access retires here; the PC advances at the end of this cycle.
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and request registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      f3_q        <= '0;
      alo_q       <= '0;
      load_data_q <= '0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      f3_q        <= f3_d;
      alo_q       <= alo_d;
      load_data_q <= load_data_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign load_data = load_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: one task per scenario.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        memread, memwrite;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data;
  logic [31:0] load_data;
  logic        stall, misaligned, bus_error;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  load_store_unit #(.MAX_WAIT(15), .CNT_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .memread    (memread),
    .memwrite   (memwrite),
    .funct3     (funct3),
    .addr       (addr),
    .store_data (store_data),
    .load_data  (load_data),
    .stall      (stall),
    .misaligned (misaligned),
    .bus_error  (bus_error),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_be     (mem_be),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Drive one access and answer it after `waits` ACCESS cycles (waits<0: never).
  // Returns in the DONE cycle with the request inputs still applied.
  task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] sd,
                            input logic [31:0] rdata, input int waits,
                            output int stalls, output int acc,
                            output logic [3:0] cap_be, output logic [31:0] cap_wdata,
                            output logic [31:0] cap_addr, output logic cap_we);
    stalls = 0; acc = 0;
    cap_be = 'x; cap_wdata = 'x; cap_addr = 'x; cap_we = 1'bx;
    memread = rd; memwrite = wr; funct3 = f3; addr = a; store_data = sd;
    #1;
    for (int c = 0; c < 40; c++) begin
      if (!stall) break;
      stalls++;
      if (mem_req) begin
        if (acc == 0) begin
          cap_be = mem_be; cap_wdata = mem_wdata; cap_addr = mem_addr; cap_we = mem_we;
        end
        if (acc == waits) begin
          mem_ready = 1'b1;
          mem_rdata = rdata;
        end
        acc++;
      end
      @(posedge clk);
      #1;
      mem_ready = 1'b0;
      mem_rdata = 32'h0;
      #1;
    end
  endtask

  task automatic go_idle();
    memread = 1'b0; memwrite = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %0b want 0", mem_req); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got %0b want 0", mem_we); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr got %h want 0", mem_addr); end
    checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_wdata got %h want 0", mem_wdata); end
    checks++; if (mem_be !== 4'h0) begin errors++; $display("FAIL reset_mem_be got %b want 0000", mem_be); end
    checks++; if (load_data !== 32'h0) begin errors++; $display("FAIL reset_load_data got %h want 0", load_data); end
    checks++; if (stall !== 1'b0 || bus_error !== 1'b0 || misaligned !== 1'b0) begin
      errors++; $display("FAIL reset_flags got stall=%0b berr=%0b mis=%0b want 000", stall, bus_error, misaligned);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_sw();
    int st, ac; logic [3:0] be; logic [31:0] wd, ma; logic we;
    run_access(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0, st, ac, be, wd, ma, we);
    checks++; if (st != 2) begin errors++; $display("FAIL sw_stall_cycles got %0d want 2", st); end
    checks++; if (be !== 4'b1111) begin errors++; $display("FAIL sw_be got %b want 1111", be); end
    checks++; if (wd !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_wdata got %h want deadbeef", wd); end
    checks++; if (ma !== 32'h100) begin errors++; $display("FAIL sw_addr got %h want 00000100", ma); end
    checks++; if (we !== 1'b1) begin errors++; $display("FAIL sw_we got %b want 1", we); end
    // DONE cycle: memwrite still high, yet no new request and no stall.
    checks++; if (stall !== 1'b0 || mem_req !== 1'b0) begin
      errors++; $display("FAIL sw_done got stall=%0b req=%0b want 0 0", stall, mem_req);
    end
    checks++; if (load_data !== 32'h0) begin errors++; $display("FAIL sw_load_data got %h want 0", load_data); end
    go_idle();
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL sw_no_relaunch got req=%0b want 0", mem_req); end
  endtask

  task automatic test_lb();
    int st, ac; logic [3:0] be; logic [31:0] wd, ma; logic we;
    run_access(1'b1, 1'b0, 3'b000, 32'h203, 32'h0, 32'h80FF1234, 3, st, ac, be, wd, ma, we);
    checks++; if (st != 5) begin errors++; $display("FAIL lb_stall_cycles got %0d want 5", st); end
    checks++; if (be !== 4'b1000) begin errors++; $display("FAIL lb_be got %b want 1000", be); end
    checks++; if (ma !== 32'h200) begin errors++; $display("FAIL lb_addr got %h want 00000200", ma); end
    checks++; if (load_data !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_data got %h want ffffff80", load_data); end
    go_idle();
    run_access(1'b1, 1'b0, 3'b100, 32'h203, 32'h0, 32'h80FF1234, 3, st, ac, be, wd, ma, we);
    checks++; if (st != 5) begin errors++; $display("FAIL lbu_stall_cycles got %0d want 5", st); end
    checks++; if (load_data !== 32'h00000080) begin errors++; $display("FAIL lbu_data got %h want 00000080", load_data); end
    go_idle();
  endtask

  task automatic test_sh();
    int st, ac; logic [3:0] be; logic [31:0] wd, ma; logic we;
    run_access(1'b0, 1'b1, 3'b001, 32'h12, 32'h0000ABCD, 32'h0, 0, st, ac, be, wd, ma, we);
    checks++; if (be !== 4'b1100) begin errors++; $display("FAIL sh_be got %b want 1100", be); end
    checks++; if (wd !== 32'hABCDABCD) begin errors++; $display("FAIL sh_wdata got %h want abcdabcd", wd); end
    checks++; if (ma !== 32'h10) begin errors++; $display("FAIL sh_addr got %h want 00000010", ma); end
    checks++; if (load_data !== 32'h00000080) begin errors++; $display("FAIL sh_keeps_load_data got %h want 00000080", load_data); end
    go_idle();
  endtask

  task automatic test_halfword_loads();
    int st, ac; logic [3:0] be; logic [31:0] wd, ma; logic we;
    run_access(1'b1, 1'b0, 3'b001, 32'h2, 32'h0, 32'h80010000, 0, st, ac, be, wd, ma, we);
    checks++; if (load_data !== 32'hFFFF8001) begin errors++; $display("FAIL lh_data got %h want ffff8001", load_data); end
    checks++; if (be !== 4'b1100) begin errors++; $display("FAIL lh_be got %b want 1100", be); end
    go_idle();
    run_access(1'b1, 1'b0, 3'b101, 32'h2, 32'h0, 32'h80010000, 0, st, ac, be, wd, ma, we);
    checks++; if (load_data !== 32'h00008001) begin errors++; $display("FAIL lhu_data got %h want 00008001", load_data); end
    go_idle();
    run_access(1'b0, 1'b1, 3'b000, 32'h1, 32'h000000A5, 32'h0, 0, st, ac, be, wd, ma, we);
    checks++; if (be !== 4'b0010 || wd !== 32'hA5A5A5A5) begin
      errors++; $display("FAIL sb_fields got be=%b wdata=%h want 0010 a5a5a5a5", be, wd);
    end
    go_idle();
  endtask

  task automatic test_faults();
    memread = 1'b1; memwrite = 1'b0; funct3 = 3'b010; addr = 32'h101;
    #1;
    checks++; if (misaligned !== 1'b1 || stall !== 1'b0 || bus_error !== 1'b0) begin
      errors++; $display("FAIL lw_misaligned got mis=%0b stall=%0b berr=%0b want 1 0 0", misaligned, stall, bus_error);
    end
    tick();
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL lw_misaligned_req got %0b want 0", mem_req); end
    funct3 = 3'b011; addr = 32'h100;
    #1;
    checks++; if (bus_error !== 1'b1 || stall !== 1'b0 || misaligned !== 1'b0) begin
      errors++; $display("FAIL illegal_load got berr=%0b stall=%0b mis=%0b want 1 0 0", bus_error, stall, misaligned);
    end
    tick();
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL illegal_load_req got %0b want 0", mem_req); end
    memread = 1'b0; memwrite = 1'b1; funct3 = 3'b100;
    #1;
    checks++; if (bus_error !== 1'b1 || stall !== 1'b0) begin
      errors++; $display("FAIL illegal_store got berr=%0b stall=%0b want 1 0", bus_error, stall);
    end
    memread = 1'b1; memwrite = 1'b1; funct3 = 3'b010;
    #1;
    checks++; if (bus_error !== 1'b1 || stall !== 1'b0) begin
      errors++; $display("FAIL rd_and_wr got berr=%0b stall=%0b want 1 0", bus_error, stall);
    end
    memread = 1'b0; memwrite = 1'b1; funct3 = 3'b001; addr = 32'h13;
    #1;
    checks++; if (misaligned !== 1'b1 || stall !== 1'b0) begin
      errors++; $display("FAIL sh_misaligned got mis=%0b stall=%0b want 1 0", misaligned, stall);
    end
    go_idle();
    checks++; if (mem_req !== 1'b0 || bus_error !== 1'b0) begin
      errors++; $display("FAIL faults_idle got req=%0b berr=%0b want 0 0", mem_req, bus_error);
    end
  endtask

  task automatic test_timeout();
    int st, ac; logic [3:0] be; logic [31:0] wd, ma; logic we;
    run_access(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 32'h0, -1, st, ac, be, wd, ma, we);
    checks++; if (ac != 15) begin errors++; $display("FAIL timeout_access_cycles got %0d want 15", ac); end
    checks++; if (st != 16) begin errors++; $display("FAIL timeout_stall_cycles got %0d want 16", st); end
    checks++; if (bus_error !== 1'b1) begin errors++; $display("FAIL timeout_bus_error got %0b want 1", bus_error); end
    checks++; if (load_data !== 32'h0) begin errors++; $display("FAIL timeout_load_data got %h want 0", load_data); end
    go_idle();
    checks++; if (bus_error !== 1'b0) begin errors++; $display("FAIL timeout_pulse_len got %0b want 0", bus_error); end
  endtask

  task automatic test_reset_mid_access();
    int st, ac; logic [3:0] be; logic [31:0] wd, ma; logic we;
    run_access(1'b1, 1'b0, 3'b010, 32'h80, 32'h0, 32'h12345678, 0, st, ac, be, wd, ma, we);
    checks++; if (load_data !== 32'h12345678) begin errors++; $display("FAIL lw_data got %h want 12345678", load_data); end
    go_idle();
    memread = 1'b1; funct3 = 3'b010; addr = 32'h84;
    tick();
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rst_mid_access1 got req=%0b want 1", mem_req); end
    tick();
    reset = 1'b1; memread = 1'b0;
    tick();
    reset = 1'b0;
    mem_ready = 1'b1; mem_rdata = 32'hCAFEF00D;
    #1;
    checks++; if (mem_req !== 1'b0 || stall !== 1'b0) begin
      errors++; $display("FAIL rst_mid_after got req=%0b stall=%0b want 0 0", mem_req, stall);
    end
    checks++; if (load_data !== 32'h0) begin errors++; $display("FAIL rst_mid_load_data got %h want 0", load_data); end
    tick();
    mem_ready = 1'b0; mem_rdata = 32'h0;
    checks++; if (load_data !== 32'h0 || mem_req !== 1'b0 || bus_error !== 1'b0) begin
      errors++; $display("FAIL rst_mid_ignored got data=%h req=%0b berr=%0b want 0 0 0", load_data, mem_req, bus_error);
    end
  endtask

  initial begin
    reset = 1'b1; memread = 1'b0; memwrite = 1'b0; funct3 = 3'b000;
    addr = 32'h0; store_data = 32'h0; mem_ready = 1'b0; mem_rdata = 32'h0;
    test_reset();
    test_sw();
    test_lb();
    test_sh();
    test_halfword_loads();
    test_faults();
    test_timeout();
    test_reset_mid_access();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
